// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the 4x4 systolic-array sequencer,
// its step counter, and the array/memory blocks that size themselves from N.
package sa_pkg;

    localparam int N            = 4;
    localparam int INST_DEPTH   = 8;
    localparam int INST_AW      = 3;
    localparam int K_W          = 4;
    localparam int FEED_AW      = 8;
    localparam int DRAIN_CYCLES = 2 * N - 2;
    localparam int CNT_W        = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_CLEAR  = 3'd3,
        S_FEED   = 3'd4,
        S_DRAIN  = 3'd5,
        S_WRITE  = 3'd6,
        S_DONE   = 3'd7
    } sa_state_e;

endpackage

// File: rtl/sa_step_counter.sv
// Loadable down-counter with a zero flag; times both the FEED and DRAIN phases.
module sa_step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sa_sequencer.sv
// Instruction-driven sequencer for the 4x4 systolic matmul engine.
// Optional cycle counter `perf_cycles` is built only when SA_SEQ_PERF_EN is defined.
module sa_sequencer
    import sa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ap_start,
    output logic               ap_end,
    output logic               busy,
    output logic               inst_rd_en,
    output logic [INST_AW-1:0] inst_addr,
    input  logic [K_W-1:0]     inst_data,
    output logic               feed_en,
    output logic [FEED_AW-1:0] feed_addr,
    output logic               array_clr,
    output logic               out_wr_en,
`ifdef SA_SEQ_PERF_EN
    output logic [15:0]        perf_cycles,
`endif
    output logic [3:0]         inst_done_cnt
);

    localparam logic [INST_AW-1:0] LAST_ADDR = INST_AW'(INST_DEPTH - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);

    sa_state_e          state, next_state;
    logic [K_W-1:0]     k_reg;
    logic [FEED_AW-1:0] feed_base;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic               start_acc;

    // Outputs decode only the state register, so no input reaches an output.
    assign ap_end     = (state == S_DONE);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign inst_rd_en = (state == S_FETCH);
    assign array_clr  = (state == S_CLEAR);
    assign feed_en    = (state == S_FEED);
    assign out_wr_en  = (state == S_WRITE);
    assign start_acc  = ap_start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counter is loaded with length-1 so the zero flag marks the last cycle of a phase.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (ap_start) next_state = S_FETCH;
            end
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = (inst_data == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: begin
                cnt_load   = 1'b1;
                cnt_val    = CNT_W'(k_reg - 1'b1);
                next_state = S_FEED;
            end
            S_FEED: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    cnt_val    = DRAIN_LD;
                    next_state = S_DRAIN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_zero) next_state = S_WRITE;
                else          cnt_dec    = 1'b1;
            end
            S_WRITE: next_state = (inst_addr == LAST_ADDR) ? S_DONE : S_FETCH;
            default: next_state = S_IDLE;
        endcase
    end

    sa_step_counter #(.W(CNT_W)) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_addr     <= '0;
            feed_base     <= '0;
            feed_addr     <= '0;
            k_reg         <= '0;
            inst_done_cnt <= '0;
        end else begin
            if (start_acc) begin
                inst_addr     <= '0;
                feed_base     <= '0;
                inst_done_cnt <= '0;
            end
            if (state == S_DECODE) k_reg <= inst_data;
            if (state == S_CLEAR)  feed_addr <= feed_base;
            if (state == S_FEED)   feed_addr <= feed_addr + 1'b1;
            if (state == S_WRITE) begin
                feed_base     <= feed_base + FEED_AW'(k_reg);
                inst_done_cnt <= inst_done_cnt + 1'b1;
                if (inst_addr != LAST_ADDR) inst_addr <= inst_addr + 1'b1;
            end
        end
    end

`ifdef SA_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 16'hFFFF)) begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// Directed bench for sa_sequencer: a timing model predicts feed/write events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sa_sequencer;
    import sa_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ap_start = 1'b0;
    logic               ap_end, busy, inst_rd_en, feed_en, array_clr, out_wr_en;
    logic [INST_AW-1:0] inst_addr;
    logic [K_W-1:0]     inst_data = '0;
    logic [FEED_AW-1:0] feed_addr;
    logic [3:0]         inst_done_cnt;
`ifdef SA_SEQ_PERF_EN
    logic [15:0]        perf_cycles;
`endif

    sa_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .ap_start      (ap_start),
        .ap_end        (ap_end),
        .busy          (busy),
        .inst_rd_en    (inst_rd_en),
        .inst_addr     (inst_addr),
        .inst_data     (inst_data),
        .feed_en       (feed_en),
        .feed_addr     (feed_addr),
        .array_clr     (array_clr),
        .out_wr_en     (out_wr_en),
`ifdef SA_SEQ_PERF_EN
        .perf_cycles   (perf_cycles),
`endif
        .inst_done_cnt (inst_done_cnt)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory with one-cycle read latency.
    logic [K_W-1:0] imem [INST_DEPTH];
    always @(posedge clk) if (inst_rd_en) inst_data <= imem[inst_addr];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [39:0] exp_feed_q[$];   // {absolute cycle, feed_addr}
    logic [31:0] exp_wr_q[$];     // absolute cycle of out_wr_en
    int exp_done_cyc;
    int exp_cnt;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Predict event cycles from the documented timing: FETCH at c, CLEAR c+2,
    // feeds c+3.., WRITE at c+K+2N+1, next FETCH right after WRITE.
    task automatic model(input int s);
        int c;
        int base;
        c = s + 1;
        base = 0;
        exp_cnt = 0;
        exp_done_cyc = -1;
        for (int a = 0; a < INST_DEPTH; a++) begin
            int k;
            k = int'(imem[a]);
            if (k == 0) begin
                exp_done_cyc = c + 2;
                break;
            end
            for (int i = 0; i < k; i++)
                exp_feed_q.push_back({32'(c + 3 + i), 8'((base + i) % 256)});
            exp_wr_q.push_back(32'(c + k + 2 * N + 1));
            base = (base + k) % 256;
            exp_cnt++;
            c = c + k + 2 * N + 2;
            if (a == INST_DEPTH - 1) exp_done_cyc = c;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && feed_en) begin
            if (exp_feed_q.size() == 0) check("feed_unexpected", 1, 0);
            else begin
                logic [39:0] e;
                e = exp_feed_q.pop_front();
                check("feed_cycle", cyc, int'(e[39:8]));
                check("feed_addr", int'(feed_addr), int'(e[7:0]));
            end
        end
        if (!rst && out_wr_en) begin
            if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_cycle", cyc, int'(exp_wr_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_prog(input logic [K_W-1:0] p [INST_DEPTH]);
        for (int i = 0; i < INST_DEPTH; i++) imem[i] = p[i];
    endtask

    // Pulses ap_start for one edge; returns s so that spec cycle n is cyc == s+n.
    task automatic start(output int s);
        @(negedge clk);
        s = cyc;
        model(s);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        check("fetch_rd_en", int'(inst_rd_en), 1);
        check("busy_c1", int'(busy), 1);
        check("ap_end_clr", int'(ap_end), 0);
    endtask

    task automatic wait_done(input int s, input string tag);
        int n;
        n = 0;
        while (!ap_end && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, int'(n >= 2000), 0);
        check({tag, "_done_cyc"}, cyc - s, exp_done_cyc - s);
        check({tag, "_done_cnt"}, int'(inst_done_cnt), exp_cnt);
        check({tag, "_busy"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_feed_q"}, exp_feed_q.size(), 0);
        check({tag, "_wr_q"}, exp_wr_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [K_W-1:0] p [INST_DEPTH];
        int s;

        for (int i = 0; i < INST_DEPTH; i++) begin
            imem[i] = '0;
            p[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ap_end", int'(ap_end), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_feed_en", int'(feed_en), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        check("rst_inst_addr", int'(inst_addr), 0);
        check("rst_done_cnt", int'(inst_done_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // [4,0] with a stray ap_start in the middle of FEED.
        p[0] = 4'd4;
        load_prog(p);
        start(s);
        while (cyc < s + 5) @(negedge clk);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        check("ignored_start_state", int'(feed_en), 1);
        wait_done(s, "k4");
`ifdef SA_SEQ_PERF_EN
        check("perf_k4", int'(perf_cycles), 16);
`endif
        repeat (3) @(negedge clk);
        check("ap_end_hold", int'(ap_end), 1);

        // [3,5,0], restarted straight from DONE.
        p[0] = 4'd3; p[1] = 4'd5; p[2] = 4'd0;
        load_prog(p);
        start(s);
        wait_done(s, "k35");

        // All entries 15: no halt, DONE after the last address.
        for (int i = 0; i < INST_DEPTH; i++) p[i] = 4'd15;
        load_prog(p);
        start(s);
        wait_done(s, "k15");
        check("k15_inst_addr", int'(inst_addr), INST_DEPTH - 1);

        // Randomised two-instruction program.
        p[0] = 4'($urandom_range(1, 15));
        p[1] = 4'($urandom_range(1, 15));
        for (int i = 2; i < INST_DEPTH; i++) p[i] = '0;
        load_prog(p);
        start(s);
        wait_done(s, "rand");

        // Reset during DRAIN abandons the block; no write may follow.
        p[0] = 4'd4; p[1] = 4'd0;
        load_prog(p);
        start(s);
        while (cyc < s + 10) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_wr_q.delete();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_feed_addr", int'(feed_addr), 0);
        check("mid_rst_inst_addr", int'(inst_addr), 0);
        check("mid_rst_done_cnt", int'(inst_done_cnt), 0);
        check("mid_rst_ap_end", int'(ap_end), 0);
`ifdef SA_SEQ_PERF_EN
        check("mid_rst_perf", int'(perf_cycles), 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        start(s);
        wait_done(s, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
